// File: rtl/button_encoder.sv
// ============================================================================
// Module   : button_encoder
// Purpose  : Synchronise, debounce and priority-encode four active-low push
//            buttons. Emits a 2-bit code plus a one-clock acceptance pulse.
//            Optional macro BUTTON_AUTO_REPEAT_EN adds hold-to-repeat pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_encoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] rawButtons,
    output logic [1:0] pushbuttons,
    output logic       pushButtonSignal,
    output logic [3:0] buttonsHeld
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || DEBOUNCE_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_encoder: illegal parameter value");
    end

    logic [3:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0]                  settle_q;
    logic                        settled;
    logic [3:0]                  sync_rel;
    logic [3:0]                  pressed;
    logic [3:0]                  armed_q, armed_d;
    state_t                      state_q [4];
    state_t                      state_d [4];
    logic [CNT_W-1:0]            cnt_q [4];
    logic [CNT_W-1:0]            cnt_d [4];
    logic [3:0]                  press_ev;
    logic [1:0]                  code_q, code_d;
    logic                        pulse_q, pulse_d;
    logic [3:0]                  held_q, held_d;
    logic                        rep_fire;
    logic [1:0]                  held_idx;

    // The synchroniser is preset to "released"; until it has refilled with
    // real samples its output is ignored so a held button cannot arm itself.
    assign settled = (settle_q == 2'(SYNC_STAGES));

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sync_rel[i] = sync_q[i][SYNC_STAGES-1];
            pressed[i]  = settled & ~sync_rel[i];
        end
        armed_d = armed_q | ({4{settled}} & sync_rel);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= '1;
            settle_q <= '0;
            armed_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], rawButtons[i]};
            end
            if (!settled) begin
                settle_q <= settle_q + 2'd1;
            end
            armed_q <= armed_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            press_ev[i] = 1'b0;
            case (state_q[i])
                RELEASED: begin
                    if (pressed[i] && armed_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i]  = HELD;
                        press_ev[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = RELEASED;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
            held_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;
    logic [2:0]       held_cnt;

    always_comb begin
        held_cnt = 3'd0;
        held_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (state_q[i] == HELD) begin
                held_cnt = held_cnt + 3'd1;
                held_idx = 2'(i);
            end
        end
    end

    // Any new press restarts the delay, so a fresh HELD entry is timed from zero.
    always_comb begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if ((|press_ev) || (held_cnt != 3'd1)) begin
            rep_d       = '0;
            rep_first_d = 1'b0;
        end else if (!rep_first_q) begin
            if (rep_q == REP_W'(REPEAT_DELAY - 1)) begin
                rep_fire    = 1'b1;
                rep_d       = '0;
                rep_first_d = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end else begin
            if (rep_q == REP_W'(REPEAT_PERIOD - 1)) begin
                rep_fire = 1'b1;
                rep_d    = '0;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rep_q       <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
    assign held_idx = 2'd0;
`endif

    // Descending scan so the lowest-index press event is the one kept.
    always_comb begin
        pulse_d = 1'b0;
        code_d  = code_q;
        for (int i = 3; i >= 0; i--) begin
            if (press_ev[i]) begin
                pulse_d = 1'b1;
                code_d  = 2'(i);
            end
        end
        if (!pulse_d && rep_fire) begin
            pulse_d = 1'b1;
            code_d  = held_idx;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            code_q  <= 2'b00;
            pulse_q <= 1'b0;
            held_q  <= 4'b0000;
        end else begin
            code_q  <= code_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    assign pushbuttons      = code_q;
    assign pushButtonSignal = pulse_q;
    assign buttonsHeld      = held_q;

endmodule

`default_nettype wire

// File: tb/tb_button_encoder.sv
// ============================================================================
// Module   : tb_button_encoder
// Purpose  : Directed self-checking bench for button_encoder (SYNC=2, DEB=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_encoder;

    logic       clock;
    logic       resetn;
    logic [3:0] rawButtons;
    logic [1:0] pushbuttons;
    logic       pushButtonSignal;
    logic [3:0] buttonsHeld;

    int n_checks = 0;
    int n_errors = 0;
    int pe [8];
    int np;
    int first;

    button_encoder #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .rawButtons       (rawButtons),
        .pushbuttons      (pushbuttons),
        .pushButtonSignal (pushButtonSignal),
        .buttonsHeld      (buttonsHeld)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps n rising edges (local edge 0 is the first one), sampling 1 time
    // unit after each edge and logging the edge index of every pulse.
    task automatic run(input int n, output int cnt, output int first_edge);
        cnt        = 0;
        first_edge = -1;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (pushButtonSignal) begin
                if (cnt < 8) pe[cnt] = k;
                if (first_edge < 0) first_edge = k;
                cnt++;
            end
        end
    endtask

    initial begin
        resetn     = 1'b0;
        rawButtons = 4'hF;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_code", int'(pushbuttons), 0);
        check_eq("rst_pulse", int'(pushButtonSignal), 0);
        check_eq("rst_held", int'(buttonsHeld), 0);
        resetn = 1'b1;
        run(5, np, first);
        check_eq("idle_pulses", np, 0);

        // Clean PB1 press
        rawButtons = 4'b1101;
        run(8, np, first);
        check_eq("clean_npulse", np, 1);
        check_eq("clean_edge", first, 7);
        check_eq("clean_code", int'(pushbuttons), 1);
        check_eq("clean_held", int'(buttonsHeld), 4'b0010);
        run(100, np, first);
        check_eq("hold_npulse", np, 0);
        rawButtons = 4'hF;
        run(10, np, first);
        check_eq("rel1_npulse", np, 0);
        check_eq("rel1_held", int'(buttonsHeld), 0);

        // PB3 bounce then stable press
        for (int j = 0; j < 5; j++) begin
            rawButtons = 4'b0111;
            run(2, np, first);
            check_eq("bounce_lo", np, 0);
            rawButtons = 4'b1111;
            run(2, np, first);
            check_eq("bounce_hi", np, 0);
        end
        rawButtons = 4'b0111;
        run(8, np, first);
        check_eq("bounce_npulse", np, 1);
        check_eq("bounce_edge", first, 7);
        check_eq("bounce_code", int'(pushbuttons), 3);
        check_eq("bounce_held", int'(buttonsHeld), 4'b1000);
        rawButtons = 4'hF;
        run(10, np, first);
        check_eq("rel3_held", int'(buttonsHeld), 0);

        // PB1 and PB3 together: lowest index wins
        rawButtons = 4'b0101;
        run(8, np, first);
        check_eq("simul_npulse", np, 1);
        check_eq("simul_edge", first, 7);
        check_eq("simul_code", int'(pushbuttons), 1);
        check_eq("simul_held", int'(buttonsHeld), 4'b1010);
        rawButtons = 4'b0111;
        run(10, np, first);
        check_eq("simul_rel_npulse", np, 0);
        check_eq("simul_rel_held", int'(buttonsHeld), 4'b1000);
        rawButtons = 4'b0101;
        run(8, np, first);
        check_eq("repress_npulse", np, 1);
        check_eq("repress_edge", first, 7);
        check_eq("repress_code", int'(pushbuttons), 1);
        check_eq("repress_held", int'(buttonsHeld), 4'b1010);
        rawButtons = 4'hF;
        run(10, np, first);
        check_eq("rel_all_held", int'(buttonsHeld), 0);

        // PB2 release glitch
        rawButtons = 4'b1011;
        run(8, np, first);
        check_eq("pb2_npulse", np, 1);
        check_eq("pb2_code", int'(pushbuttons), 2);
        rawButtons = 4'b1111;
        run(2, np, first);
        rawButtons = 4'b1011;
        run(10, np, first);
        check_eq("glitch_npulse", np, 0);
        check_eq("glitch_held", int'(buttonsHeld), 4'b0100);
        rawButtons = 4'b1111;
        run(8, np, first);
        check_eq("pb2_rel_npulse", np, 0);
        check_eq("pb2_rel_held", int'(buttonsHeld), 0);

        // Reset mid-debounce with PB1 still held afterwards
        rawButtons = 4'b1101;
        run(3, np, first);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_code", int'(pushbuttons), 0);
        check_eq("async_rst_pulse", int'(pushButtonSignal), 0);
        check_eq("async_rst_held", int'(buttonsHeld), 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        run(20, np, first);
        check_eq("post_rst_npulse", np, 0);
        check_eq("post_rst_held", int'(buttonsHeld), 0);
        rawButtons = 4'hF;
        run(10, np, first);
        rawButtons = 4'b1101;
        run(8, np, first);
        check_eq("rearm_npulse", np, 1);
        check_eq("rearm_edge", first, 7);
        check_eq("rearm_code", int'(pushbuttons), 1);
        rawButtons = 4'hF;
        run(10, np, first);

`ifdef BUTTON_AUTO_REPEAT_EN
        rawButtons = 4'b1110;
        run(28, np, first);
        check_eq("rep_npulse", np, 4);
        check_eq("rep_e0", pe[0], 7);
        check_eq("rep_e1", pe[1], 17);
        check_eq("rep_e2", pe[2], 22);
        check_eq("rep_e3", pe[3], 27);
        check_eq("rep_code", int'(pushbuttons), 0);
        rawButtons = 4'b1100;
        run(40, np, first);
        check_eq("rep_stop_npulse", np, 2);
        check_eq("rep_stop_e0", pe[0], 4);
        check_eq("rep_stop_e1", pe[1], 7);
        check_eq("rep_stop_code", int'(pushbuttons), 1);
        rawButtons = 4'hF;
        run(10, np, first);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
